// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter and its ALU.
package alu_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SRL  = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32-style integer ALU; alu_en=0 degrades every op to a plain add.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        funct7_4,
  input  logic        alu_en,
  input  logic        alu_imm,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = a + b;
    if (alu_en) begin
      case (funct3)
        F3_ADD:  result = (funct7_4 && !alu_imm) ? (a - b) : (a + b);
        F3_SLL:  result = a << shamt;
        F3_SLT:  result = {31'd0, $signed(a) < $signed(b)};
        F3_SLTU: result = {31'd0, a < b};
        F3_XOR:  result = a ^ b;
        F3_SRL: begin
          if (funct7_4) result = $signed(a) >>> shamt;
          else          result = a >> shamt;
        end
        F3_OR:   result = a | b;
        F3_AND:  result = a & b;
        default: result = a + b;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; the winner's result is held in a response register.
//  state | meaning
//  IDLE  | no result pending, o_rsp_valid=0
//  HOLD  | result pending in o_rsp_data/o_rsp_id, o_rsp_valid=1
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [63:0]      i_req_a,
  input  logic [63:0]      i_req_b,
  input  logic [5:0]       i_req_funct3,
  input  logic [1:0]       i_req_funct7_4,
  input  logic [1:0]       i_req_alu_en,
  input  logic [1:0]       i_req_alu_imm,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_data,
  output logic             o_rsp_id,
  output logic [CNT_W-1:0] o_op_count
);

  arb_state_t  state, state_nxt;
  logic        last_grant;
  logic [1:0]  grant;
  logic        can_accept;
  logic        accept;
  logic        gid;
  logic [31:0] sel_a, sel_b;
  logic [2:0]  sel_funct3;
  logic [31:0] alu_result;

  always_comb begin
    grant = 2'b00;
    case (i_req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (FIXED_PRIO != 0) grant = 2'b01;
        else                 grant = last_grant ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

  // A slot opens when nothing is pending or the pending result leaves this cycle.
  assign o_rsp_valid = (state == HOLD);
  assign can_accept  = i_rst_n & (~o_rsp_valid | i_rsp_ready);
  assign o_req_ready = grant & {NUM_REQ{can_accept}};
  assign accept      = |(o_req_ready & i_req_valid);
  assign gid         = grant[1];

  assign sel_a      = gid ? i_req_a[63:32] : i_req_a[31:0];
  assign sel_b      = gid ? i_req_b[63:32] : i_req_b[31:0];
  assign sel_funct3 = gid ? i_req_funct3[5:3] : i_req_funct3[2:0];

  alu u_alu (
    .a        (sel_a),
    .b        (sel_b),
    .funct3   (sel_funct3),
    .funct7_4 (i_req_funct7_4[gid]),
    .alu_en   (i_req_alu_en[gid]),
    .alu_imm  (i_req_alu_imm[gid]),
    .result   (alu_result)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = HOLD;
      HOLD: begin
        if (accept)           state_nxt = HOLD;
        else if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_rsp_data <= 32'd0;
      o_rsp_id   <= 1'b0;
      o_op_count <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        o_rsp_data <= alu_result;
        o_rsp_id   <= gid;
        last_grant <= gid;
        o_op_count <= o_op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, random run against a reference model, fixed-priority wrap check.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [5:0]  req_f3;
  logic [1:0]  req_f7, req_en, req_imm;
  logic        rsp_ready;

  logic [1:0]  rdy0, rdy1;
  logic        rv0, rv1, rid0, rid1;
  logic [31:0] rd0, rd1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  alu_arbiter #(.FIXED_PRIO(0), .CNT_W(16)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy0),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_funct3(req_f3), .i_req_funct7_4(req_f7),
    .i_req_alu_en(req_en), .i_req_alu_imm(req_imm), .o_rsp_valid(rv0),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rd0), .o_rsp_id(rid0), .o_op_count(cnt0)
  );

  alu_arbiter #(.FIXED_PRIO(1), .CNT_W(3)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy1),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_funct3(req_f3), .i_req_funct7_4(req_f7),
    .i_req_alu_en(req_en), .i_req_alu_imm(req_imm), .o_rsp_valid(rv1),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rd1), .o_rsp_id(rid1), .o_op_count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic f7,
                                          input logic en, input logic im);
    int sh;
    sh = int'(b[4:0]);
    if (!en) return a + b;
    case (f)
      3'd0: begin
        if (f7 && !im) return a - b;
        return a + b;
      end
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (f7) return $signed(a) >>> sh;
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  typedef struct {
    logic        rst_n;
    logic [1:0]  valid;
    logic [63:0] a, b;
    logic [5:0]  f3;
    logic [1:0]  f7, en, imm;
    logic        rsp_ready;
    logic [1:0]  exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_id;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl[16];

  // Reference model state for the round-robin instance.
  logic        m_v, m_id, m_last;
  logic [31:0] m_d;
  logic [15:0] m_c;

  task automatic model_cycle();
    logic [1:0] g, exp_rdy, acc;
    int k;
    #1;
    g = 2'b00;
    if (req_valid == 2'b01)      g = 2'b01;
    else if (req_valid == 2'b10) g = 2'b10;
    else if (req_valid == 2'b11) g = 2'b01 << (1 - int'(m_last));
    exp_rdy = (rst_n && (!m_v || rsp_ready)) ? g : 2'b00;
    chk("rnd_ready", {30'd0, rdy0}, {30'd0, exp_rdy});
    @(posedge clk);
    if (!rst_n) begin
      m_v = 1'b0; m_d = 32'd0; m_id = 1'b0; m_c = 16'd0; m_last = 1'b1;
    end else begin
      acc = exp_rdy & req_valid;
      if (acc != 2'b00) begin
        k = acc[1] ? 1 : 0;
        m_d = alu_ref(req_a[32*k +: 32], req_b[32*k +: 32], req_f3[3*k +: 3],
                      req_f7[k], req_en[k], req_imm[k]);
        m_id = acc[1];
        m_last = acc[1];
        m_c = m_c + 16'd1;
        m_v = 1'b1;
      end else if (m_v && rsp_ready) begin
        m_v = 1'b0;
      end
    end
    #1;
    chk("rnd_valid", {31'd0, rv0}, {31'd0, m_v});
    chk("rnd_count", {16'd0, cnt0}, {16'd0, m_c});
    if (m_v || !rst_n) chk("rnd_data", rd0, m_d);
    if (m_v) chk("rnd_id", {31'd0, rid0}, {31'd0, m_id});
  endtask

  localparam logic [63:0] A_CONT = {32'h8000_0001, 32'd3};
  localparam logic [63:0] B_CONT = {32'd30, 32'd7};
  localparam logic [5:0]  F_CONT = {3'd5, 3'd0};

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_f3 = '0;
    req_f7 = '0; req_en = 2'b11; req_imm = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //          rst valid a                           b                           f3      f7     en     imm    rr    ready  v     data           id    cnt
    tbl[0]  = '{1'b0, 2'b00, 64'd0, 64'd0, 6'o00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 2'b01, {32'd0, 32'd3}, {32'd0, 32'd7}, 6'o00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 32'h0000_000A, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 2'b01, {32'd0, 32'd3}, {32'd0, 32'd7}, 6'o00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 2'b11, A_CONT, B_CONT, F_CONT, 2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 32'hFFFF_FFFC, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 2'b11, A_CONT, B_CONT, F_CONT, 2'b11, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 32'hFFFF_FFFE, 1'b1, 16'd2};
    tbl[5]  = '{1'b1, 2'b11, A_CONT, B_CONT, F_CONT, 2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 32'hFFFF_FFFC, 1'b0, 16'd3};
    tbl[6]  = '{1'b1, 2'b11, A_CONT, B_CONT, F_CONT, 2'b11, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 32'hFFFF_FFFE, 1'b1, 16'd4};
    tbl[7]  = '{1'b1, 2'b01, {32'd0, 32'hFF00_FF00}, {32'd0, 32'hF00F_F00F}, 6'o04, 2'b00, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 32'h0F0F_0F0F, 1'b0, 16'd5};
    tbl[8]  = '{1'b1, 2'b11, {32'h1234, 32'h5555}, {32'h9, 32'h77}, 6'o04, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0F0F_0F0F, 1'b0, 16'd5};
    tbl[9]  = '{1'b1, 2'b11, {32'hAAAA, 32'h0}, {32'h1, 32'h1}, 6'o21, 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0F0F_0F0F, 1'b0, 16'd5};
    tbl[10] = '{1'b1, 2'b11, {32'hFFFF, 32'h3}, {32'h2, 32'h4}, 6'o76, 2'b01, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0F0F_0F0F, 1'b0, 16'd5};
    tbl[11] = '{1'b1, 2'b00, 64'd0, 64'd0, 6'o00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0F0F_0F0F, 1'b0, 16'd5};
    tbl[12] = '{1'b1, 2'b10, {32'd1, 32'd0}, {32'd1, 32'd0}, 6'o70, 2'b10, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, 32'h0000_0002, 1'b1, 16'd6};
    tbl[13] = '{1'b1, 2'b00, 64'd0, 64'd0, 6'o00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_0002, 1'b1, 16'd6};
    tbl[14] = '{1'b0, 2'b11, A_CONT, B_CONT, F_CONT, 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0};
    tbl[15] = '{1'b1, 2'b11, A_CONT, B_CONT, F_CONT, 2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFC, 1'b0, 16'd1};

    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; req_valid = tbl[i].valid; req_a = tbl[i].a; req_b = tbl[i].b;
      req_f3 = tbl[i].f3; req_f7 = tbl[i].f7; req_en = tbl[i].en; req_imm = tbl[i].imm;
      rsp_ready = tbl[i].rsp_ready;
      #1;
      chk($sformatf("row%0d_ready", i), {30'd0, rdy0}, {30'd0, tbl[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", i), {31'd0, rv0}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("row%0d_count", i), {16'd0, cnt0}, {16'd0, tbl[i].exp_count});
      if (tbl[i].exp_valid || !tbl[i].rst_n) chk($sformatf("row%0d_data", i), rd0, tbl[i].exp_data);
      if (tbl[i].exp_valid) chk($sformatf("row%0d_id", i), {31'd0, rid0}, {31'd0, tbl[i].exp_id});
    end

    // Random traffic with occasional resets and response stalls.
    m_v = 1'b0; m_d = 32'd0; m_id = 1'b0; m_c = 16'd0; m_last = 1'b1;
    rst_n = 1'b0;
    model_cycle();
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      req_valid = 2'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = ($urandom_range(0, 3) == 0) ? req_a : {$urandom, $urandom};
      req_f3    = 6'($urandom);
      req_f7    = 2'($urandom);
      req_en    = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      req_imm   = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      model_cycle();
    end

    // Fixed-priority instance: requester 0 always wins, 3-bit counter wraps.
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("fp_reset_valid", {31'd0, rv1}, 32'd0);
    chk("fp_reset_count", {29'd0, cnt1}, 32'd0);
    rst_n = 1'b1; req_f3 = 6'o00; req_f7 = 2'b00; req_en = 2'b11; req_imm = 2'b00;
    for (int i = 0; i < 9; i++) begin
      req_a = {32'd100, 32'(i)};
      req_b = {32'd5, 32'd1};
      #1;
      chk($sformatf("fp%0d_ready", i), {30'd0, rdy1}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("fp%0d_valid", i), {31'd0, rv1}, 32'd1);
      chk($sformatf("fp%0d_id", i), {31'd0, rid1}, 32'd0);
      chk($sformatf("fp%0d_data", i), rd1, 32'(i + 1));
      chk($sformatf("fp%0d_count", i), {29'd0, cnt1}, {29'd0, 3'(i + 1)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin, 1 = requester 0 always wins.
REQ-002 SHALL have parameter CNT_W, default 16: width of the accepted-operation counter.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  synchronous, active-low reset.
REQ-005 i_req_valid  input  2  per-requester operation valid; bit k = requester k.
REQ-006 o_req_ready  output  2  per-requester accept; a transfer occurs when valid[k] & ready[k].
REQ-007 i_req_a  input  64  operand A; bits [32k+31:32k] belong to requester k.
REQ-008 i_req_b  input  64  operand B, packed as i_req_a.
REQ-009 i_req_funct3  input  6  funct3 per requester, bits [3k+2:3k].
REQ-010 i_req_funct7_4  input  2  funct7 bit 4 per requester (SUB/SRA select).
REQ-011 i_req_alu_en  input  2  ALU enable per requester; 0 forces plain ADD.
REQ-012 i_req_alu_imm  input  2  immediate-form flag per requester; SUB suppressed when set.
REQ-013 o_rsp_valid  output  1  result pending.
REQ-014 i_rsp_ready  input  1  consumer accepts result.
REQ-015 o_rsp_data  output  32  registered ALU result.
REQ-016 o_rsp_id  output  1  requester index that owns o_rsp_data.
REQ-017 o_op_count  output  CNT_W  number of accepted operations, wraps modulo 2^CNT_W.

Function
REQ-018 One shared alu instance SHALL be driven combinationally from the granted requester's fields; only one operation accepted per cycle.
REQ-019 States: IDLE (o_rsp_valid=0), HOLD (o_rsp_valid=1); IDLE->HOLD on accept; HOLD->IDLE on rsp handshake with no new accept; HOLD->HOLD on rsp handshake plus same-cycle accept.
REQ-020 Grant: single valid requester wins; both valid -> FIXED_PRIO=1 gives 0, else requester other than last_grant.
REQ-021 last_grant SHALL update only on an accepted transfer, never on valid alone.
REQ-022 o_req_ready[k] = grant[k] & (!o_rsp_valid | i_rsp_ready); at most one bit high; ready may depend combinationally on valid.
REQ-023 Latency: accept in cycle N -> o_rsp_valid, o_rsp_data, o_rsp_id valid at cycle N+1; full throughput of one op/cycle when i_rsp_ready held high.
REQ-024 While o_rsp_valid=1 and i_rsp_ready=0, o_rsp_data and o_rsp_id SHALL stay stable and both o_req_ready bits SHALL be 0.
REQ-025 Requester inputs SHALL be sampled only in the accept cycle; later changes do not affect the pending result.
REQ-026 o_op_count SHALL increment by 1 per accept, wrap from all-ones to 0, unaffected by response stalls.
REQ-027 ALU semantics SHALL be those of the shared alu: funct3 0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND; shift amount = B[4:0].

Reset
REQ-028 On i_rst_n=0 at a clock edge: o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_op_count=0, last_grant=1, state IDLE.
REQ-029 During reset o_req_ready SHALL be 2'b00; a pending result is discarded, not delivered.

Structure
REQ-030 Shared package alu_pkg SHALL hold funct3 constants (F3_ADD..F3_AND), the IDLE/HOLD state type and requester-count constant 2.
REQ-031 The single sub-module SHALL be the existing alu; arbitration, response register and counter live in alu_arbiter.

Verification
REQ-032 Req0 only, ADD a=3 b=7, rsp_ready=1 -> next cycle rsp_valid=1, data=0000000A, id=0, count=1.
REQ-033 Both valid every cycle, req0 SUB 3-7, req1 SRA 80000001>>30, rsp_ready=1 -> grants 0,1,0,1; data FFFFFFFC / FFFFFFFE alternating.
REQ-034 Backpressure: rsp_ready=0 for 3 cycles after accept of XOR ff00ff00^f00ff00f -> data 0F0F0F0F held, ready=00, count unchanged.
REQ-035 FIXED_PRIO=1, both valid 4 cycles -> requester 0 accepted 4 times, requester 1 ready never high.
REQ-036 Reset asserted while o_rsp_valid=1 -> next cycle rsp_valid=0, data=0, count=0; first post-reset contention grants requester 0.
REQ-037 alu_en=0 with funct3=7 funct7_4=1, a=1 b=1 -> data=00000002.
